// File: rtl/param_regfile_sb.sv
// param_regfile_sb: 2-read/1-write register file with write-through bypass,
// optional hardwired-zero r0, selectable read latency and pending scoreboard.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   rd_addr1/2          read addresses
//   rd_data1/2          read data (bypassed from the write port on a hit)
//   rd_pend1/2          pending flag of the addressed register
//   wr_en/addr/data     writeback port; clears the pending bit
//   iss_en/addr         issue port; sets the pending bit
//   busy_any            OR of all registered pending bits
module param_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_any
);

  localparam int NREGS = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = wr_en  && !(ZR && (wr_addr == '0));
  assign iss_ok = iss_en && !(ZR && (iss_addr == '0));

  // Storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: issue is applied after writeback so that a
  // same-cycle issue (the newer producer) keeps the bit set.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) begin
      pend_nxt[wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      pend_nxt[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign busy_any = |pend;

  // Combinational read with write-through bypass
  logic              zero1;
  logic              zero2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] data1_c;
  logic [DATA_W-1:0] data2_c;
  logic              pend1_c;
  logic              pend2_c;

  assign zero1 = ZR && (rd_addr1 == '0);
  assign zero2 = ZR && (rd_addr2 == '0);

  assign hit1 = wr_en && (wr_addr == rd_addr1) && !zero1;
  assign hit2 = wr_en && (wr_addr == rd_addr2) && !zero2;

  always_comb begin
    data1_c = regs[rd_addr1];
    if (zero1) begin
      data1_c = '0;
    end else if (hit1) begin
      data1_c = wr_data;
    end
  end

  always_comb begin
    data2_c = regs[rd_addr2];
    if (zero2) begin
      data2_c = '0;
    end else if (hit2) begin
      data2_c = wr_data;
    end
  end

  // A writeback in flight resolves the hazard for this reader.
  assign pend1_c = pend[rd_addr1] & ~hit1;
  assign pend2_c = pend[rd_addr2] & ~hit2;

  generate
    if (READ_LAT == 0) begin : g_comb
      assign rd_data1 = data1_c;
      assign rd_data2 = data2_c;
      assign rd_pend1 = pend1_c;
      assign rd_pend2 = pend2_c;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_data1 <= '0;
          rd_data2 <= '0;
          rd_pend1 <= 1'b0;
          rd_pend2 <= 1'b0;
        end else begin
          rd_data1 <= data1_c;
          rd_data2 <= data2_c;
          rd_pend1 <= pend1_c;
          rd_pend2 <= pend2_c;
        end
      end
    end
  endgenerate

endmodule
